execute_stage: RTL

Execute stage of the pipelined RISC-V core, directly downstream of the ALU decoder. It takes the decoded ID/EX bundle, including the 3-bit ALU control code, and selects operands, with optional forwarding. It computes the ALU result, resolves BEQ branches and captures the result in the EX/MEM pipeline register, with stall and flush control.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu.sv | 29 ++
 rtl/execute_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings and writeback-select encodings, common to the
// ALU decoder and the execute stage.
package alu_pkg;

  localparam int ALU_CTRL_W   = 3;
  localparam int RESULT_SRC_W = 2;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;

  typedef enum logic [RESULT_SRC_W-1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_t;

endpackage

// File: rtl/alu.sv
// Combinational XLEN-wide ALU: add/sub/and/or/slt, unused codes yield 0.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]       a,
  input  logic [XLEN-1:0]       b,
  input  logic [ALU_CTRL_W-1:0] alu_control,
  output logic [XLEN-1:0]       result,
  output logic                  zero
);

  // Operation select; slt is a signed compare zero-extended to XLEN.
  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// RISC-V execute stage: operand select, ALU, BEQ resolution and EX/MEM register.
// Optional operand forwarding from MEM/WB is enabled by defining FORWARDING_EN.
module execute_stage
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    ex_valid_i,
  input  logic [XLEN-1:0]         rd1_i,
  input  logic [XLEN-1:0]         rd2_i,
  input  logic [XLEN-1:0]         imm_i,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [REG_ADDR_W-1:0]   rs1_addr_i,
  input  logic [REG_ADDR_W-1:0]   rs2_addr_i,
  input  logic [REG_ADDR_W-1:0]   rd_addr_i,
  input  logic [ALU_CTRL_W-1:0]   alu_control_i,
  input  logic                    alu_src_i,
  input  logic                    reg_write_i,
  input  logic                    mem_write_i,
  input  logic                    branch_i,
  input  logic [RESULT_SRC_W-1:0] result_src_i,
  input  logic [XLEN-1:0]         wb_result_i,
  input  logic [REG_ADDR_W-1:0]   wb_rd_addr_i,
  input  logic                    wb_reg_write_i,
  output logic                    mem_valid_o,
  output logic [XLEN-1:0]         mem_alu_result_o,
  output logic [XLEN-1:0]         mem_write_data_o,
  output logic [REG_ADDR_W-1:0]   mem_rd_addr_o,
  output logic                    mem_reg_write_o,
  output logic                    mem_mem_write_o,
  output logic [RESULT_SRC_W-1:0] mem_result_src_o,
  output logic                    pc_src_o,
  output logic [XLEN-1:0]         pc_target_o
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_rs2;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

`ifdef FORWARDING_EN
  // MEM-stage match wins over WB; x0 is never forwarded. Loads are stalled
  // upstream, so the MEM ALU result is forwarded whatever result_src says.
  function automatic logic [XLEN-1:0] fwd_select(
    input logic [REG_ADDR_W-1:0] rs_addr,
    input logic [XLEN-1:0]       rf_value,
    input logic                  m_valid,
    input logic                  m_reg_write,
    input logic [REG_ADDR_W-1:0] m_rd_addr,
    input logic [XLEN-1:0]       m_result,
    input logic                  w_reg_write,
    input logic [REG_ADDR_W-1:0] w_rd_addr,
    input logic [XLEN-1:0]       w_result
  );
    logic [XLEN-1:0] sel;
    sel = rf_value;
    if ((rs_addr != '0) && m_valid && m_reg_write && (m_rd_addr == rs_addr)) begin
      sel = m_result;
    end else if ((rs_addr != '0) && w_reg_write && (w_rd_addr == rs_addr)) begin
      sel = w_result;
    end else begin
      sel = rf_value;
    end
    return sel;
  endfunction

  // Forwarding muxes for both source operands.
  always_comb begin
    src_a   = fwd_select(rs1_addr_i, rd1_i, mem_valid_o, mem_reg_write_o,
                         mem_rd_addr_o, mem_alu_result_o,
                         wb_reg_write_i, wb_rd_addr_i, wb_result_i);
    src_rs2 = fwd_select(rs2_addr_i, rd2_i, mem_valid_o, mem_reg_write_o,
                         mem_rd_addr_o, mem_alu_result_o,
                         wb_reg_write_i, wb_rd_addr_i, wb_result_i);
  end
`else
  logic unused_fwd_inputs;

  assign src_a   = rd1_i;
  assign src_rs2 = rd2_i;
  assign unused_fwd_inputs = ^{rs1_addr_i, rs2_addr_i, wb_result_i,
                               wb_rd_addr_i, wb_reg_write_i};
`endif

  // Operand B select: immediate or (forwarded) rs2.
  always_comb begin
    src_b = src_rs2;
    if (alu_src_i) begin
      src_b = imm_i;
    end else begin
      src_b = src_rs2;
    end
  end

  alu #(
    .XLEN(XLEN)
  ) u_alu (
    .a          (src_a),
    .b          (src_b),
    .alu_control(alu_control_i),
    .result     (alu_result),
    .zero       (alu_zero)
  );

  assign pc_target_o = pc_i + imm_i;
  assign pc_src_o    = ex_valid_i & branch_i & alu_zero;

  // EX/MEM register: reset > flush (bubble, data held) > stall (hold) > load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid_o      <= 1'b0;
      mem_alu_result_o <= '0;
      mem_write_data_o <= '0;
      mem_rd_addr_o    <= '0;
      mem_reg_write_o  <= 1'b0;
      mem_mem_write_o  <= 1'b0;
      mem_result_src_o <= '0;
    end else if (flush_i) begin
      mem_valid_o      <= 1'b0;
      mem_reg_write_o  <= 1'b0;
      mem_mem_write_o  <= 1'b0;
      mem_result_src_o <= '0;
    end else if (!stall_i) begin
      mem_valid_o      <= ex_valid_i;
      mem_alu_result_o <= alu_result;
      mem_write_data_o <= src_rs2;
      mem_rd_addr_o    <= rd_addr_i;
      mem_reg_write_o  <= ex_valid_i & reg_write_i;
      mem_mem_write_o  <= ex_valid_i & mem_write_i;
      mem_result_src_o <= ex_valid_i ? result_src_i : {RESULT_SRC_W{1'b0}};
    end
  end

endmodule
